// File: rtl/gcd_avalon_master.sv
// Avalon-MM initiator that runs the GCD slave protocol (write A, write B, poll, read result)
// on behalf of a valid/ready operand stream. Optional zero bypass: GCD_MASTER_ZERO_BYPASS_EN.
module gcd_avalon_master #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 3,
  parameter int READ_LATENCY = 1,
  parameter int POLL_LIMIT   = 1024
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_gcd,
  output logic              rsp_timeout,
  output logic              m_chipselect,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_write,
  output logic              m_read,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_waitrequest
);

  // state     | meaning
  // IDLE      | ready for an operand pair
  // WR_A      | writing operand A to address 0
  // WR_B      | writing operand B to address 1
  // POLL_RD   | reading control register (address 2)
  // POLL_WAIT | waiting READ_LATENCY for control data, checking done bit
  // RES_RD    | reading result register (address 3)
  // RES_WAIT  | waiting READ_LATENCY for result data
  // RSP       | presenting result until consumed
  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, POLL_RD, POLL_WAIT, RES_RD, RES_WAIT, RSP
  } state_t;

  localparam int PCNT_W = $clog2(POLL_LIMIT + 1);
  localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(READ_LATENCY - 1);
  localparam logic [PCNT_W-1:0] POLL_MAX = PCNT_W'(POLL_LIMIT);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [PCNT_W-1:0]   poll_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic                started;
  logic                accept, lat_done, zero_op, poll_exhausted;
  logic                cs_int, rd_int, wr_int;

  assign accept         = req_valid && req_ready;
  assign lat_done       = (lat_cnt == '0);
  assign poll_exhausted = (poll_cnt >= POLL_MAX);

`ifdef GCD_MASTER_ZERO_BYPASS_EN
  assign zero_op = (req_a == '0) || (req_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = zero_op ? RSP : WR_A;
      WR_A:      if (!m_waitrequest) state_nxt = WR_B;
      WR_B:      if (!m_waitrequest) state_nxt = POLL_RD;
      POLL_RD:   if (!m_waitrequest) state_nxt = POLL_WAIT;
      POLL_WAIT: if (lat_done) begin
                   if (m_readdata[0])        state_nxt = RES_RD;
                   else if (!poll_exhausted) state_nxt = POLL_RD;
                   else                      state_nxt = RSP;
                 end
      RES_RD:    if (!m_waitrequest) state_nxt = RES_WAIT;
      RES_WAIT:  if (lat_done) state_nxt = RSP;
      RSP:       if (rsp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // req_ready is held off until one full cycle out of reset
  always_comb begin
    req_ready   = (state == IDLE) && started && resetn;
    rsp_valid   = (state == RSP) && resetn;
    cs_int      = 1'b0;
    rd_int      = 1'b0;
    wr_int      = 1'b0;
    m_address   = '0;
    m_writedata = '0;
    case (state)
      WR_A:    begin cs_int = 1'b1; wr_int = 1'b1; m_address = ADDR_W'(0); m_writedata = a_q; end
      WR_B:    begin cs_int = 1'b1; wr_int = 1'b1; m_address = ADDR_W'(1); m_writedata = b_q; end
      POLL_RD: begin cs_int = 1'b1; rd_int = 1'b1; m_address = ADDR_W'(2); end
      RES_RD:  begin cs_int = 1'b1; rd_int = 1'b1; m_address = ADDR_W'(3); end
      default: ;
    endcase
    m_chipselect = cs_int && resetn;
    m_read       = rd_int && resetn;
    m_write      = wr_int && resetn;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      started     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      poll_cnt    <= '0;
      lat_cnt     <= '0;
      rsp_gcd     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          a_q <= req_a;
          b_q <= req_b;
          if (zero_op) begin
            rsp_gcd     <= req_a | req_b;
            rsp_timeout <= 1'b0;
          end
        end
        WR_B: if (!m_waitrequest) poll_cnt <= '0;
        POLL_RD: if (!m_waitrequest) begin
          poll_cnt <= poll_cnt + 1'b1;
          lat_cnt  <= LAT_LOAD;
        end
        POLL_WAIT: begin
          if (!lat_done) lat_cnt <= lat_cnt - 1'b1;
          else if (!m_readdata[0] && poll_exhausted) begin
            rsp_gcd     <= '0;
            rsp_timeout <= 1'b1;
          end
        end
        RES_RD: if (!m_waitrequest) lat_cnt <= LAT_LOAD;
        RES_WAIT: begin
          if (!lat_done) lat_cnt <= lat_cnt - 1'b1;
          else begin
            rsp_gcd     <= m_readdata;
            rsp_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_avalon_master.sv
// Directed bench for gcd_avalon_master with a behavioural GCD slave and a response scoreboard.
module tb_gcd_avalon_master;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int RL = 1;
  localparam int PL = 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_gcd;
  logic          rsp_timeout;
  logic          m_chipselect;
  logic [AW-1:0] m_address;
  logic          m_write;
  logic          m_read;
  logic [DW-1:0] m_writedata;
  logic [DW-1:0] m_readdata = '0;
  logic          m_waitrequest = 1'b0;

  always #5 clock = ~clock;

  gcd_avalon_master #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL), .POLL_LIMIT(PL)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd), .rsp_timeout(rsp_timeout),
    .m_chipselect(m_chipselect), .m_address(m_address), .m_write(m_write), .m_read(m_read),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
  );

  int tests = 0;
  int fails = 0;
  logic [DW:0] exp_q[$];

  // slave model state and bus log
  int            stall_cfg = 0, stall_left = 0, done_after = 0, polls = 0;
  int            wr0_cnt = 0, wr1_cnt = 0, rd2_cnt = 0, rd3_cnt = 0, cs_cnt = 0, bus_err = 0;
  logic [DW-1:0] sa = '0, sb = '0, wr0_data = '0, wr1_data = '0, pend_data = '0;
  logic          pend_valid = 1'b0, prev_stall = 1'b0;
  logic [AW+DW+2:0] snap = '0;

  function automatic logic [DW-1:0] gcd_f(input logic [DW-1:0] x0, input logic [DW-1:0] y0);
    logic [DW-1:0] x, y, t;
    x = x0; y = y0;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  always @(negedge clock) begin
    m_readdata = pend_valid ? pend_data : 32'hDEADBEEF;
    pend_valid = 1'b0;
    if (prev_stall && snap !== {m_chipselect, m_read, m_write, m_address, m_writedata}) bus_err++;
    if (m_read && m_write) bus_err++;
    if (m_chipselect !== (m_read || m_write)) bus_err++;
    if (m_chipselect) cs_cnt++;
    if (!resetn) begin
      polls = 0; stall_left = stall_cfg; m_waitrequest = 1'b0; prev_stall = 1'b0;
    end else if (m_chipselect && (m_read || m_write)) begin
      if (stall_left > 0) begin
        m_waitrequest = 1'b1; stall_left--; prev_stall = 1'b1;
        snap = {m_chipselect, m_read, m_write, m_address, m_writedata};
      end else begin
        m_waitrequest = 1'b0; prev_stall = 1'b0; stall_left = stall_cfg;
        if (m_write && m_address == 0) begin sa = m_writedata; wr0_cnt++; wr0_data = m_writedata; end
        else if (m_write && m_address == 1) begin sb = m_writedata; wr1_cnt++; wr1_data = m_writedata; end
        else if (m_read && m_address == 2) begin
          polls++; rd2_cnt++;
          pend_data = 32'h0000_0054 | ((done_after != 0 && polls >= done_after) ? 32'd1 : 32'd0);
          pend_valid = 1'b1;
        end else if (m_read && m_address == 3) begin
          rd3_cnt++; polls = 0; pend_data = gcd_f(sa, sb); pend_valid = 1'b1;
        end else bus_err++;
      end
    end else begin
      m_waitrequest = 1'b0; prev_stall = 1'b0; stall_left = stall_cfg;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr0_cnt = 0; wr1_cnt = 0; rd2_cnt = 0; rd3_cnt = 0; bus_err = 0;
    wr0_data = '0; wr1_data = '0;
  endtask

  task automatic send_req(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit push,
                          input logic [DW-1:0] eg, input logic et);
    int n;
    if (push) exp_q.push_back({et, eg});
    req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clock); n++; end
    check("req_accept_bound", 64'(n < 200), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [DW:0] e;
    check({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_gcd"}, 64'(rsp_gcd), 64'(e[DW-1:0]));
    check({tag, "_timeout"}, 64'(rsp_timeout), 64'(e[DW]));
  endtask

  task automatic get_rsp(input int delay, input string tag);
    int n, bad;
    logic [DW-1:0] g;
    logic t;
    n = 0;
    while (!rsp_valid && n < 500) begin @(negedge clock); n++; end
    check({tag, "_rsp_bound"}, 64'(n < 500), 64'd1);
    g = rsp_gcd; t = rsp_timeout; bad = 0;
    repeat (delay) begin
      @(negedge clock);
      if (rsp_valid !== 1'b1 || rsp_gcd !== g || rsp_timeout !== t) bad++;
    end
    if (delay > 0) check({tag, "_rsp_stable"}, 64'(bad), 64'd0);
    pop_check(tag);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic check_bus(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int n_poll, input int n_res);
    check({tag, "_wr0_cnt"}, 64'(wr0_cnt), 64'd1);
    check({tag, "_wr0_data"}, 64'(wr0_data), 64'(a));
    check({tag, "_wr1_cnt"}, 64'(wr1_cnt), 64'd1);
    check({tag, "_wr1_data"}, 64'(wr1_data), 64'(b));
    check({tag, "_poll_reads"}, 64'(rd2_cnt), 64'(n_poll));
    check({tag, "_res_reads"}, 64'(rd3_cnt), 64'(n_res));
    check({tag, "_bus_err"}, 64'(bus_err), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_gcd"}, 64'(rsp_gcd), 64'd0);
    check({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
    check({tag, "_strobes"}, 64'({m_chipselect, m_read, m_write}), 64'd0);
    check({tag, "_addr_wdata"}, 64'({m_address, m_writedata}), 64'd0);
  endtask

  initial begin
    int n, bad, cs0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    resetn = 1'b1;
    @(negedge clock);
    check("reset_release_ready", 64'(req_ready), 64'd1);

    // basic pair, done on third poll
    stall_cfg = 0; done_after = 3; clear_log();
    send_req(48, 18, 1, 6, 0);
    get_rsp(0, "t1");
    check_bus("t1", 48, 18, 3, 1);

    // same pair with 4-cycle waitrequest on every transfer
    stall_cfg = 4; done_after = 3; clear_log();
    send_req(48, 18, 1, 6, 0);
    get_rsp(0, "t2");
    check_bus("t2", 48, 18, 3, 1);

    // slave never finishes: exactly PL polls then timeout
    stall_cfg = 0; done_after = 0; clear_log();
    send_req(1000, 10, 1, 0, 1);
    get_rsp(3, "t3");
    check_bus("t3", 1000, 10, PL, 0);

    // backpressure in RSP while the next pair waits
    done_after = 1; clear_log();
    send_req(48, 18, 1, 6, 0);
    n = 0;
    while (!rsp_valid && n < 500) begin @(negedge clock); n++; end
    check("t4_rsp_bound", 64'(n < 500), 64'd1);
    req_a = 35; req_b = 21; req_valid = 1'b1;
    exp_q.push_back({1'b0, 32'd7});
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
    end
    check("t4_hold_ready_low", 64'(bad), 64'd0);
    check("t4_no_second_start", 64'(wr0_cnt), 64'd1);
    pop_check("t4a");
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    clear_log();
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    check("t4_second_accept_bound", 64'(n < 50), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    get_rsp(0, "t4b");
    check_bus("t4b", 35, 21, 1, 1);

    // reset pulse while waiting on a poll result
    done_after = 0; clear_log();
    send_req(100, 30, 0, 0, 0);
    n = 0;
    while (!(rd2_cnt >= 1 && !m_read) && n < 200) begin @(negedge clock); n++; end
    check("t5_poll_wait_bound", 64'(n < 200), 64'd1);
    resetn = 1'b0;
    @(negedge clock);
    check_reset_vals("t5_reset");
    resetn = 1'b1;
    @(negedge clock);
    check("t5_ready_back", 64'(req_ready), 64'd1);
    done_after = 2; clear_log();
    send_req(17, 5, 1, 1, 0);
    get_rsp(0, "t5");
    check_bus("t5", 17, 5, 2, 1);

    // zero operand
    done_after = 1; clear_log(); cs0 = cs_cnt;
    send_req(0, 42, 1, 42, 0);
`ifdef GCD_MASTER_ZERO_BYPASS_EN
    check("t6_bypass_latency", 64'(rsp_valid), 64'd1);
    get_rsp(0, "t6");
    check("t6_no_chipselect", 64'(cs_cnt - cs0), 64'd0);
    check("t6_no_writes", 64'(wr0_cnt + wr1_cnt), 64'd0);
`else
    get_rsp(0, "t6");
    check_bus("t6", 0, 42, 1, 1);
`endif
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
